// File: rtl/fade_pkg.sv
// fade_pkg: shared types and helpers for the fade frame packer.
// Holds the default frame geometry, the complex sample type, the
// write/read FSM state encodings and the bit-reversal helper used when
// the packer is built with FADE_PACKER_BITREV_EN.
package fade_pkg;

    localparam int NFFT_DEFAULT = 32;
    localparam int DW_DEFAULT   = 16;

    // bitrev() works on indices up to 8 bits wide (NFFT up to 256).
    localparam int BITREV_MAX_BITS = 8;
    localparam int BITREV_IDX_W    = $clog2(BITREV_MAX_BITS);

    // One complex sample as it appears on the stream: {imag, real}.
    typedef struct packed {
        logic [DW_DEFAULT-1:0] im;
        logic [DW_DEFAULT-1:0] re;
    } cplx_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_FILL,
        W_DROP
    } wstate_t;

    typedef enum logic {
        R_IDLE,
        R_STREAM
    } rstate_t;

    // Reverse the low 'bits' bits of 'value'; upper bits of the result are 0.
    function automatic logic [BITREV_MAX_BITS-1:0] bitrev(
        input logic [BITREV_MAX_BITS-1:0] value,
        input int                         bits
    );
        logic [BITREV_MAX_BITS-1:0] result;
        logic [BITREV_IDX_W-1:0]    src;
        result = '0;
        for (int i = 0; i < BITREV_MAX_BITS; i++) begin
            src = BITREV_IDX_W'(bits - 1 - i);
            if (i < bits) begin
                result[i] = value[src];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/fade_pingpong_ram.sv
// fade_pingpong_ram: two NFFT-deep banks of {imag, real} samples in one
// simple dual-port array. The bank is the address MSB. One write port and
// one synchronous read port, so the array maps onto block or LUT RAM.
module fade_pingpong_ram
    import fade_pkg::*;
#(
    parameter int NFFT = NFFT_DEFAULT,
    parameter int DW   = DW_DEFAULT
) (
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic [$clog2(NFFT):0]   wr_addr,
    input  logic [2*DW-1:0]         wr_data,
    input  logic                    rd_en,
    input  logic [$clog2(NFFT):0]   rd_addr,
    output logic [2*DW-1:0]         rd_data
);

    logic [2*DW-1:0] mem [0:2*NFFT-1];

    // Write port and registered read port.
    // NOTE: the array has no reset; a reset term would stop RAM inference,
    // and stale contents are harmless because the bank full flags reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fade_frame_packer.sv
// fade_frame_packer: packs the fader's per-channel sample stream into
// complete NFFT-point frames (ping-pong banks) and streams each finished
// frame out as an AXI4-Stream burst with tlast and full tready backpressure.
// Sequence errors and dropped frames are reported as sticky flags.
// Build option: define FADE_PACKER_BITREV_EN to emit each frame in
// bit-reversed slot order instead of natural order.
module fade_frame_packer
    import fade_pkg::*;
#(
    parameter int NFFT = NFFT_DEFAULT,
    parameter int DW   = DW_DEFAULT
) (
    input  logic                    clk,
    input  logic                    aresetn,
    input  logic                    dv_in,
    input  logic [$clog2(NFFT)-1:0] chan_in,
    input  logic [DW-1:0]           din_imag,
    input  logic [DW-1:0]           din_real,
    output logic [2*DW-1:0]         m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    input  logic                    clear_status,
    output logic                    overflow,
    output logic                    seq_err,
    output logic [15:0]             frame_count
);

    localparam int            AW        = $clog2(NFFT);
    localparam logic [AW-1:0] LAST_CHAN = AW'(NFFT - 1);
    localparam logic [AW-1:0] ONE_CHAN  = AW'(1);
    localparam logic [AW:0]   ONE_CNT   = (AW + 1)'(1);

    // ---------------------------------------------------------------
    // Write side
    // ---------------------------------------------------------------
    wstate_t       w_state;
    wstate_t       w_next;
    logic          wbank;
    logic [AW-1:0] w_expect;
    logic [1:0]    full;
    logic          wr_en;
    logic          frame_done;
    logic          ovf_evt;
    logic          seq_evt;

    logic chan_zero;
    logic chan_last;
    logic chan_match;

    assign chan_zero  = (chan_in == '0);
    assign chan_last  = (chan_in == LAST_CHAN);
    assign chan_match = (chan_in == w_expect);

    // ---------------------------------------------------------------
    // Read side
    // ---------------------------------------------------------------
    rstate_t       r_state;
    rstate_t       r_next;
    logic          rbank;
    logic [AW:0]   rd_cnt;      // slots issued so far in this frame
    logic [AW-1:0] rd_addr;
    logic          rd_issue;
    logic          rd_valid;    // RAM output register holds a slot
    logic          rd_last;     // ... and that slot is the frame's last beat
    logic [2*DW-1:0] ram_q;

    // Two-entry output buffer; entry 0 is the head presented downstream.
    logic [1:0]      fifo_cnt;
    logic [2*DW-1:0] ent0_data;
    logic [2*DW-1:0] ent1_data;
    logic            ent0_last;
    logic            ent1_last;
    logic            pop;
    logic            tlast_hs;
    logic [1:0]      occ_after_pop;

    assign m_axis_tvalid = (fifo_cnt != 2'd0);
    assign m_axis_tdata  = ent0_data;
    assign m_axis_tlast  = ent0_last && m_axis_tvalid;

    assign pop      = m_axis_tvalid && m_axis_tready;
    assign tlast_hs = pop && ent0_last;

    // Slots that will sit in the buffer once this cycle's pop is done,
    // counting the one already in the RAM output register.
    assign occ_after_pop = fifo_cnt + {1'b0, rd_valid} - {1'b0, pop};

`ifdef FADE_PACKER_BITREV_EN
    assign rd_addr = AW'(bitrev(BITREV_MAX_BITS'(rd_cnt[AW-1:0]), AW));
`else
    assign rd_addr = rd_cnt[AW-1:0];
`endif

    fade_pingpong_ram #(
        .NFFT (NFFT),
        .DW   (DW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr ({wbank, chan_in}),
        .wr_data ({din_imag, din_real}),
        .rd_en   (rd_issue),
        .rd_addr ({rbank, rd_addr}),
        .rd_data (ram_q)
    );

    // Write FSM state register.
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values, independent of block order.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            w_state <= W_IDLE;
        end else begin
            w_state <= w_next;
        end
    end

    // Write FSM next state: frame start, in-order fill, drop on no free bank.
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and infers a latch.
    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE: begin
                if (dv_in && chan_zero) begin
                    w_next = full[wbank] ? W_DROP : W_FILL;
                end
            end
            W_FILL: begin
                if (dv_in) begin
                    if (chan_match) begin
                        if (chan_last) begin
                            w_next = W_IDLE;
                        end
                    end else if (!chan_zero) begin
                        w_next = W_IDLE;
                    end
                end
            end
            W_DROP: begin
                if (dv_in && chan_zero && !full[wbank]) begin
                    w_next = W_FILL;
                end
            end
            default: w_next = W_IDLE;
        endcase
    end

    // Write FSM outputs: RAM write, frame completion and error events.
    always_comb begin
        wr_en      = 1'b0;
        frame_done = 1'b0;
        ovf_evt    = 1'b0;
        seq_evt    = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (dv_in && chan_zero) begin
                    if (full[wbank]) begin
                        ovf_evt = 1'b1;
                    end else begin
                        wr_en = 1'b1;
                    end
                end
            end
            W_FILL: begin
                if (dv_in) begin
                    if (chan_match) begin
                        wr_en      = 1'b1;
                        frame_done = chan_last;
                    end else begin
                        // Partial frame is abandoned; a fresh slot 0 restarts it.
                        seq_evt = 1'b1;
                        wr_en   = chan_zero;
                    end
                end
            end
            W_DROP: begin
                wr_en = dv_in && chan_zero && !full[wbank];
            end
            default: ;
        endcase
    end

    // Expected next channel and write bank pointer.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            w_expect <= '0;
            wbank    <= 1'b0;
        end else begin
            if (wr_en) begin
                w_expect <= chan_in + ONE_CHAN;
            end
            if (frame_done) begin
                wbank <= ~wbank;
            end
        end
    end

    // Bank full flags: set by the writer on completion, cleared by the
    // reader on the tlast handshake; the two always target different banks.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            full <= 2'b00;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (frame_done && (wbank == 1'(b))) begin
                    full[b] <= 1'b1;
                end else if (tlast_hs && (rbank == 1'(b))) begin
                    full[b] <= 1'b0;
                end
            end
        end
    end

    // Read FSM state register.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= r_next;
        end
    end

    // Read FSM next state: start on a full bank, finish on the tlast handshake.
    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:   if (full[rbank]) r_next = R_STREAM;
            R_STREAM: if (tlast_hs)    r_next = R_IDLE;
            default:  r_next = R_IDLE;
        endcase
    end

    // Read FSM outputs: slot 0 is fetched while leaving R_IDLE so the first
    // beat is valid two cycles after the frame completes; later slots are
    // fetched only while the output buffer has room for them.
    always_comb begin
        rd_issue = 1'b0;
        case (r_state)
            R_IDLE:   rd_issue = full[rbank];
            R_STREAM: rd_issue = !rd_cnt[AW] && (occ_after_pop < 2'd2);
            default:  rd_issue = 1'b0;
        endcase
    end

    // Read slot counter, read bank pointer and RAM-output tracking.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            rd_cnt   <= '0;
            rbank    <= 1'b0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
        end else begin
            if (tlast_hs) begin
                rd_cnt <= '0;
                rbank  <= ~rbank;
            end else if (rd_issue) begin
                rd_cnt <= rd_cnt + ONE_CNT;
            end
            rd_valid <= rd_issue;
            rd_last  <= rd_issue && (rd_cnt[AW-1:0] == LAST_CHAN);
        end
    end

    // Output buffer: holds tdata/tlast stable while stalled and absorbs the
    // RAM read already in flight when tready drops.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            fifo_cnt  <= 2'd0;
            ent0_data <= '0;
            ent0_last <= 1'b0;
            ent1_data <= '0;
            ent1_last <= 1'b0;
        end else begin
            case ({rd_valid, pop})
                2'b10: begin
                    if (fifo_cnt == 2'd0) begin
                        ent0_data <= ram_q;
                        ent0_last <= rd_last;
                    end else begin
                        ent1_data <= ram_q;
                        ent1_last <= rd_last;
                    end
                    fifo_cnt <= fifo_cnt + 2'd1;
                end
                2'b01: begin
                    ent0_data <= ent1_data;
                    ent0_last <= ent1_last;
                    fifo_cnt  <= fifo_cnt - 2'd1;
                end
                2'b11: begin
                    if (fifo_cnt == 2'd1) begin
                        ent0_data <= ram_q;
                        ent0_last <= rd_last;
                    end else begin
                        ent0_data <= ent1_data;
                        ent0_last <= ent1_last;
                        ent1_data <= ram_q;
                        ent1_last <= rd_last;
                    end
                end
                default: ;
            endcase
        end
    end

    // Sticky status and emitted-frame counter; a new event beats clear_status,
    // while clear_status beats a same-cycle frame completion.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            overflow    <= 1'b0;
            seq_err     <= 1'b0;
            frame_count <= 16'd0;
        end else begin
            overflow <= ovf_evt || (overflow && !clear_status);
            seq_err  <= seq_evt || (seq_err && !clear_status);
            if (clear_status) begin
                frame_count <= 16'd0;
            end else if (tlast_hs) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fade_frame_packer.sv
// tb_fade_frame_packer: directed bench for fade_frame_packer. A frame-level
// model (queues of completed frames) predicts every accepted beat and the
// status outputs; literal checks pin latency, order and counts.
// Honours FADE_PACKER_BITREV_EN for the expected output order.
module tb_fade_frame_packer;
    import fade_pkg::*;

    localparam int NFFT = 32;
    localparam int DW   = 16;
    localparam int LOG  = 5;

    typedef cplx_t [NFFT-1:0] frame_t;

    logic            clk;
    logic            aresetn;
    logic            dv_in;
    logic [LOG-1:0]  chan_in;
    logic [DW-1:0]   din_imag;
    logic [DW-1:0]   din_real;
    logic [2*DW-1:0] tdata;
    logic            tvalid;
    logic            tready;
    logic            tlast;
    logic            clear_status;
    logic            overflow;
    logic            seq_err;
    logic [15:0]     frame_count;

    fade_frame_packer #(.NFFT(NFFT), .DW(DW)) dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .dv_in         (dv_in),
        .chan_in       (chan_in),
        .din_imag      (din_imag),
        .din_real      (din_real),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tlast  (tlast),
        .clear_status  (clear_status),
        .overflow      (overflow),
        .seq_err       (seq_err),
        .frame_count   (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Expected output slot for the n-th beat of a frame.
    function automatic int out_slot(input int beat);
`ifdef FADE_PACKER_BITREV_EN
        int r;
        r = 0;
        for (int k = 0; k < LOG; k++) r = r * 2 + ((beat >> k) & 1);
        return r;
`else
        return beat;
`endif
    endfunction

    // ---------------- frame-level model ----------------
    frame_t      out_q[$];     // completed frames not yet fully emitted
    frame_t      wr_buf;
    frame_t      head;
    bit          m_collect, m_drop, m_ovf, m_seq;
    int          m_expect, m_beat;
    logic [15:0] m_fc;
    bit          prev_stall, prev_last;
    logic [31:0] prev_data;
    bit          hs, ovf_evt, seq_evt, last_hs;

    logic [31:0] cap_data[$];
    bit          cap_last[$];
    int          cap_cyc[$];

    always @(negedge clk) begin
        if (!aresetn) begin
            out_q.delete();
            m_collect = 0; m_drop = 0; m_ovf = 0; m_seq = 0;
            m_expect = 0; m_beat = 0; m_fc = 16'd0; prev_stall = 0;
        end else begin
            check("overflow", overflow, m_ovf);
            check("seq_err", seq_err, m_seq);
            check("frame_count", frame_count, m_fc);
            if (prev_stall) begin
                check("stall_tvalid", tvalid, 1);
                check("stall_tdata", tdata, prev_data);
                check("stall_tlast", tlast, prev_last);
            end
            if (m_beat != 0) check("midframe_tvalid", tvalid, 1);
            if (tvalid) check("beat_has_frame", out_q.size() != 0, 1);
            hs = tvalid && tready;
            ovf_evt = 0; seq_evt = 0; last_hs = 0;
            // Input sample: sees the buffers as they are before this edge.
            if (dv_in) begin
                if (m_collect) begin
                    if (int'(chan_in) == m_expect) begin
                        wr_buf[chan_in] = {din_imag, din_real};
                        m_expect++;
                        if (m_expect == NFFT) begin
                            out_q.push_back(wr_buf);
                            m_collect = 0;
                        end
                    end else begin
                        seq_evt = 1;
                        if (chan_in == 0) begin
                            wr_buf[0] = {din_imag, din_real};
                            m_expect = 1;
                        end else begin
                            m_collect = 0;
                        end
                    end
                end else if (chan_in == 0) begin
                    if (out_q.size() >= 2) begin
                        if (!m_drop) ovf_evt = 1;
                        m_drop = 1;
                    end else begin
                        m_drop = 0;
                        m_collect = 1;
                        wr_buf[0] = {din_imag, din_real};
                        m_expect = 1;
                    end
                end
            end
            if (hs && out_q.size() != 0) begin
                head = out_q[0];
                check("tdata", tdata, head[out_slot(m_beat)]);
                check("tlast", tlast, m_beat == NFFT - 1);
                cap_data.push_back(tdata);
                cap_last.push_back(tlast);
                cap_cyc.push_back(cyc);
                if (m_beat == NFFT - 1) begin
                    void'(out_q.pop_front());
                    m_beat = 0;
                    last_hs = 1;
                end else begin
                    m_beat++;
                end
            end
            m_ovf = ovf_evt || (m_ovf && !clear_status);
            m_seq = seq_evt || (m_seq && !clear_status);
            if (clear_status) m_fc = 16'd0;
            else if (last_hs) m_fc = m_fc + 16'd1;
            prev_stall = tvalid && !tready;
            prev_data  = tdata;
            prev_last  = tlast;
        end
    end

    // ---------------- stimulus ----------------
    int tready_mode = 0;   // 0 low, 1 high, 2 random

    initial begin
        tready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (tready_mode)
                0: tready = 1'b0;
                1: tready = 1'b1;
                default: tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic drive(input int ch, input int tag);
        logic [15:0] re;
        re = 16'(tag * 256 + ch);
        dv_in    = 1'b1;
        chan_in  = LOG'(ch);
        din_real = re;
        din_imag = -re;
        @(posedge clk); #1;
        dv_in = 1'b0;
    endtask

    task automatic send_frame(input int tag);
        for (int c = 0; c < NFFT; c++) drive(c, tag);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_clear();
        clear_status = 1'b1;
        @(posedge clk); #1;
        clear_status = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((out_q.size() != 0 || tvalid) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({"drain_", name}, (out_q.size() == 0) && !tvalid, 1);
        @(posedge clk); #1;
    endtask

    function automatic logic [15:0] cap_re(input int i);
        logic [31:0] d;
        d = cap_data[i];
        return d[15:0];
    endfunction

    function automatic int cap_gaps(input int skip_at);
        int g;
        g = 0;
        for (int i = 1; i < cap_cyc.size(); i++)
            if (i != skip_at && cap_cyc[i] - cap_cyc[i-1] != 1) g++;
        return g;
    endfunction

    function automatic int cap_lasts();
        int n;
        n = 0;
        foreach (cap_last[i]) if (cap_last[i]) n++;
        return n;
    endfunction

    initial begin
        logic [31:0] w;
        int n;
        aresetn = 1'b0; dv_in = 1'b0; chan_in = '0;
        din_real = '0; din_imag = '0; clear_status = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tvalid", tvalid, 0);
        check("rst_tlast", tlast, 0);
        check("rst_tdata", tdata, 0);
        check("rst_overflow", overflow, 0);
        check("rst_seq_err", seq_err, 0);
        check("rst_frame_count", frame_count, 0);
        @(posedge clk); #1;
        aresetn = 1'b1;
        idle(2);

        // T1: one clean frame, tready high.
        tready_mode = 1;
        idle(1);
        send_frame(0);
        @(negedge clk); check("lat_edge0", tvalid, 0);
        @(negedge clk); check("lat_edge1", tvalid, 0);
        @(negedge clk); check("lat_edge2", tvalid, 1);
        wait_drain("t1", 200);
        check("t1_beats", cap_data.size(), 32);
        check("t1_beat0", cap_re(0), 0);
`ifdef FADE_PACKER_BITREV_EN
        check("t1_beat1", cap_re(1), 16);
        check("t1_beat2", cap_re(2), 8);
        check("t1_beat3", cap_re(3), 24);
`else
        check("t1_beat1", cap_re(1), 1);
        check("t1_beat2", cap_re(2), 2);
        check("t1_beat3", cap_re(3), 3);
`endif
        check("t1_beat31", cap_re(31), 31);
        w = cap_data[31];
        check("t1_beat31_imag", w[31:16], 16'hFFE1);
        check("t1_tlast_count", cap_lasts(), 1);
        check("t1_tlast_pos", cap_last[31], 1);
        check("t1_no_gaps", cap_gaps(-1), 0);
        check("t1_frame_count", frame_count, 1);

        // T2: same frame with random tready.
        cap_data.delete(); cap_last.delete(); cap_cyc.delete();
        tready_mode = 2;
        send_frame(1);
        wait_drain("t2", 400);
        check("t2_beats", cap_data.size(), 32);
        check("t2_tlast_count", cap_lasts(), 1);
        check("t2_frame_count", frame_count, 2);

        // T3: three frames with tready low; the third is dropped.
        tready_mode = 0;
        idle(2);
        pulse_clear();
        cap_data.delete(); cap_last.delete(); cap_cyc.delete();
        send_frame(2);
        send_frame(3);
        send_frame(4);
        idle(2);
        @(negedge clk);
        check("t3_overflow", overflow, 1);
        check("t3_stalled_valid", tvalid, 1);
        check("t3_fc_before", frame_count, 0);
        @(posedge clk); #1;
        tready_mode = 1;
        wait_drain("t3", 300);
        check("t3_beats", cap_data.size(), 64);
        check("t3_frame1_first", cap_re(0), 16'd512);
        check("t3_frame2_first", cap_re(32), 16'd768);
        check("t3_frame2_last", cap_re(63), 16'd799);
        check("t3_tlast_count", cap_lasts(), 2);
        check("t3_no_gaps_in_frame", cap_gaps(32), 0);
        check("t3_frame_gap_le2", (cap_cyc[32] - cap_cyc[31]) <= 3, 1);
        check("t3_frame_count", frame_count, 2);

        // T4: sequence error, then restart-in-place, then clean frame.
        pulse_clear();
        @(negedge clk); check("t4_overflow_cleared", overflow, 0);
        @(posedge clk); #1;
        cap_data.delete(); cap_last.delete(); cap_cyc.delete();
        for (int c = 0; c < 10; c++) drive(c, 9);
        drive(12, 9);
        idle(10);
        @(negedge clk);
        check("t4_seq_err", seq_err, 1);
        check("t4_no_beats", cap_data.size(), 0);
        check("t4_no_valid", tvalid, 0);
        @(posedge clk); #1;
        for (int c = 0; c < 5; c++) drive(c, 8);
        send_frame(5);
        wait_drain("t4", 200);
        check("t4_beats", cap_data.size(), 32);
        check("t4_first", cap_re(0), 16'd1280);
        check("t4_last", cap_re(31), 16'd1311);
        check("t4_frame_count", frame_count, 1);

        // T5: reset for one cycle at beat 10 of a frame.
        cap_data.delete(); cap_last.delete(); cap_cyc.delete();
        send_frame(6);
        n = 0;
        while (cap_data.size() < 10 && n < 100) begin @(posedge clk); #1; n++; end
        check("t5_reach_beat10", cap_data.size() >= 10, 1);
        aresetn = 1'b0;
        @(posedge clk); #1;
        aresetn = 1'b1;
        @(negedge clk);
        check("t5_tvalid", tvalid, 0);
        check("t5_seq_err", seq_err, 0);
        check("t5_overflow", overflow, 0);
        check("t5_frame_count", frame_count, 0);
        @(posedge clk); #1;
        cap_data.delete(); cap_last.delete(); cap_cyc.delete();
        idle(6);
        check("t5_no_stray_beats", cap_data.size(), 0);
        send_frame(7);
        wait_drain("t5", 200);
        check("t5_beats", cap_data.size(), 32);
        check("t5_first", cap_re(0), 16'd1792);
        check("t5_frame_count_after", frame_count, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
